// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
// Holds FSM state enums, arbitration mode and bus widths.
package axi_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int AXI_AW      = 32;
    localparam int AXI_DW      = 32;
    localparam int AXI_SW      = AXI_DW / 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_XFER,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_e;

    // Index width for n masters; a single master still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle: AR/R/AW/W/B channels.
// master modport drives requests, slave modport drives responses.
interface axi_lite_if;
    import axi_arb_pkg::*;

    logic [AXI_AW-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [AXI_DW-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [AXI_AW-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [AXI_DW-1:0] wdata;
    logic [AXI_SW-1:0] wmask;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_lite_rr_arbiter_rr_pick.sv
// Combinational request picker: scans from ptr_i upward with wrap.
// Ports: req_i, ptr_i, mode_i in; gnt_valid_o, gnt_idx_o out.
module rr_pick
    import axi_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  arb_mode_e     mode_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_idx_o
);

    always_comb begin
        int base;
        int idx;
        base        = (mode_i == ARB_RR) ? int'(ptr_i) : 0;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        // Walk offsets high to low so the smallest offset wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = base + k;
            if (idx >= N) idx = idx - N;
            if (|(req_i & (N'(1) << idx))) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter, independent read/write paths.
// Ports: clk, reset_n, m[] (slave modports), s (master modport).
module axi_lite_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ARB_MODE    = 1,
    localparam int IW          = idx_w(NUM_MASTERS)
) (
    input logic        clk,
    input logic        reset_n,
    axi_lite_if.slave  m [NUM_MASTERS],
    axi_lite_if.master s
);

    localparam arb_mode_e MODE = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [NUM_MASTERS-1:0] arv, rrdy, awv, wv, brdy;
    logic [AXI_AW-1:0]      ara [NUM_MASTERS];
    logic [AXI_AW-1:0]      awa [NUM_MASTERS];
    logic [AXI_DW-1:0]      wd  [NUM_MASTERS];
    logic [AXI_SW-1:0]      wm  [NUM_MASTERS];

    rd_state_t     rd_state_q;
    logic [IW-1:0] rd_owner_q, rd_ptr_q, rd_ptr_d;
    logic          rd_gnt_v;
    logic [IW-1:0] rd_gnt_idx;

    wr_state_t     wr_state_q;
    logic [IW-1:0] wr_owner_q, wr_ptr_q, wr_ptr_d;
    logic          wr_gnt_v;
    logic [IW-1:0] wr_gnt_idx;
    logic          aw_done_q, w_done_q;

    logic rd_addr_ph, rd_data_ph, wr_xfer_ph, wr_resp_ph;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign rd_addr_ph = (rd_state_q == RD_ADDR);
    assign rd_data_ph = (rd_state_q == RD_DATA);
    assign wr_xfer_ph = (wr_state_q == WR_XFER);
    assign wr_resp_ph = (wr_state_q == WR_RESP);

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
        assign arv[i]  = m[i].arvalid;
        assign ara[i]  = m[i].araddr;
        assign rrdy[i] = m[i].rready;
        assign awv[i]  = m[i].awvalid;
        assign awa[i]  = m[i].awaddr;
        assign wv[i]   = m[i].wvalid;
        assign wd[i]   = m[i].wdata;
        assign wm[i]   = m[i].wmask;
        assign brdy[i] = m[i].bready;

        assign m[i].arready = rd_addr_ph && (rd_owner_q == IW'(i))
                              && s.arready;
        assign m[i].rvalid  = rd_data_ph && (rd_owner_q == IW'(i))
                              && s.rvalid;
        assign m[i].awready = wr_xfer_ph && (wr_owner_q == IW'(i))
                              && !aw_done_q && s.awready;
        assign m[i].wready  = wr_xfer_ph && (wr_owner_q == IW'(i))
                              && !w_done_q && s.wready;
        assign m[i].bvalid  = wr_resp_ph && (wr_owner_q == IW'(i))
                              && s.bvalid;
        assign m[i].rdata   = s.rdata;
        assign m[i].rresp   = s.rresp;
        assign m[i].bresp   = s.bresp;
    end

    rr_pick #(.N(NUM_MASTERS)) u_rd_pick (
        .req_i       (arv),
        .ptr_i       (rd_ptr_q),
        .mode_i      (MODE),
        .gnt_valid_o (rd_gnt_v),
        .gnt_idx_o   (rd_gnt_idx)
    );

    rr_pick #(.N(NUM_MASTERS)) u_wr_pick (
        .req_i       (awv),
        .ptr_i       (wr_ptr_q),
        .mode_i      (MODE),
        .gnt_valid_o (wr_gnt_v),
        .gnt_idx_o   (wr_gnt_idx)
    );

    // Slave-side channel muxes; only the owner select is registered.
    assign s.arvalid = rd_addr_ph && arv[rd_owner_q];
    assign s.araddr  = ara[rd_owner_q];
    assign s.rready  = rd_data_ph && rrdy[rd_owner_q];
    assign s.awvalid = wr_xfer_ph && !aw_done_q && awv[wr_owner_q];
    assign s.awaddr  = awa[wr_owner_q];
    assign s.wvalid  = wr_xfer_ph && !w_done_q && wv[wr_owner_q];
    assign s.wdata   = wd[wr_owner_q];
    assign s.wmask   = wm[wr_owner_q];
    assign s.bready  = wr_resp_ph && brdy[wr_owner_q];

    assign ar_hs = s.arvalid && s.arready;
    assign r_hs  = s.rvalid  && s.rready;
    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid  && s.wready;
    assign b_hs  = s.bvalid  && s.bready;

    // Next pointer is owner+1 with wrap; fixed priority pins it at 0.
    always_comb begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        if (MODE == ARB_RR) begin
            if (rd_owner_q != IW'(NUM_MASTERS - 1))
                rd_ptr_d = rd_owner_q + IW'(1);
            if (wr_owner_q != IW'(NUM_MASTERS - 1))
                wr_ptr_d = wr_owner_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q <= RD_IDLE;
            rd_owner_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: if (rd_gnt_v) begin
                    rd_owner_q <= rd_gnt_idx;
                    rd_state_q <= RD_ADDR;
                end
                RD_ADDR: if (ar_hs) rd_state_q <= RD_DATA;
                RD_DATA: if (r_hs) begin
                    rd_state_q <= RD_IDLE;
                    rd_ptr_q   <= rd_ptr_d;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q <= WR_IDLE;
            wr_owner_q <= '0;
            wr_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: if (wr_gnt_v) begin
                    wr_owner_q <= wr_gnt_idx;
                    wr_state_q <= WR_XFER;
                end
                WR_XFER: begin
                    // A handshake this cycle counts as done.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        wr_state_q <= WR_RESP;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done_q <= 1'b1;
                        if (w_hs)  w_done_q  <= 1'b1;
                    end
                end
                WR_RESP: if (b_hs) begin
                    wr_state_q <= WR_IDLE;
                    wr_ptr_q   <= wr_ptr_d;
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench: RR instance (4 masters) and fixed instance (3).
// Zero-wait slave models; checks via immediate assertions.
module tb_axi_lite_rr_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    axi_lite_if mr [4] ();
    axi_lite_if rs ();
    axi_lite_if mf [3] ();
    axi_lite_if fs ();

    logic [3:0]  arv, rrdy, awv, wv, brdy;
    logic [3:0]  arr, rv, awr, wr, bv;
    logic [31:0] ara [4];
    logic [31:0] awa [4];
    logic [31:0] wd  [4];
    logic [3:0]  wm  [4];
    logic [2:0]  farv, farr, frv;

    for (genvar i = 0; i < 4; i++) begin : g_mr
        assign mr[i].araddr  = ara[i];
        assign mr[i].arvalid = arv[i];
        assign mr[i].rready  = rrdy[i];
        assign mr[i].awaddr  = awa[i];
        assign mr[i].awvalid = awv[i];
        assign mr[i].wdata   = wd[i];
        assign mr[i].wmask   = wm[i];
        assign mr[i].wvalid  = wv[i];
        assign mr[i].bready  = brdy[i];
        assign arr[i] = mr[i].arready;
        assign rv[i]  = mr[i].rvalid;
        assign awr[i] = mr[i].awready;
        assign wr[i]  = mr[i].wready;
        assign bv[i]  = mr[i].bvalid;
    end

    for (genvar i = 0; i < 3; i++) begin : g_mf
        assign mf[i].araddr  = 32'h1000 + 32'(i * 16);
        assign mf[i].arvalid = farv[i];
        assign mf[i].rready  = 1'b1;
        assign mf[i].awaddr  = '0;
        assign mf[i].awvalid = 1'b0;
        assign mf[i].wdata   = '0;
        assign mf[i].wmask   = '0;
        assign mf[i].wvalid  = 1'b0;
        assign mf[i].bready  = 1'b0;
        assign farr[i] = mf[i].arready;
        assign frv[i]  = mf[i].rvalid;
    end

    // Slave for the RR instance.
    logic        s_rv, s_gaw, s_gw, s_bv, sl_wrdy;
    logic [31:0] s_rd, s_wd;
    logic [3:0]  s_wm;
    int          s_wcnt = 0;

    assign rs.arready = 1'b1;
    assign rs.rvalid  = s_rv;
    assign rs.rdata   = s_rd;
    assign rs.rresp   = 2'b00;
    assign rs.awready = !s_gaw && !s_bv;
    assign rs.wready  = sl_wrdy && !s_gw && !s_bv;
    assign rs.bvalid  = s_bv;
    assign rs.bresp   = 2'b00;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_rv <= 1'b0; s_rd <= '0;
            s_gaw <= 1'b0; s_gw <= 1'b0; s_bv <= 1'b0;
        end else begin
            if (rs.arvalid && rs.arready) begin
                s_rv <= 1'b1;
                s_rd <= rs.araddr ^ 32'h5A5A0000;
            end else if (rs.rvalid && rs.rready) begin
                s_rv <= 1'b0;
            end
            if (s_bv) begin
                if (rs.bready) s_bv <= 1'b0;
            end else if ((s_gaw || (rs.awvalid && rs.awready)) &&
                         (s_gw || (rs.wvalid && rs.wready))) begin
                s_bv <= 1'b1; s_gaw <= 1'b0; s_gw <= 1'b0;
            end else begin
                if (rs.awvalid && rs.awready) s_gaw <= 1'b1;
                if (rs.wvalid && rs.wready)   s_gw  <= 1'b1;
            end
        end
    end

    // Slave for the fixed-priority instance (read only).
    logic        f_rv;
    logic [31:0] f_rd;

    assign fs.arready = 1'b1;
    assign fs.rvalid  = f_rv;
    assign fs.rdata   = f_rd;
    assign fs.rresp   = 2'b00;
    assign fs.awready = 1'b0;
    assign fs.wready  = 1'b0;
    assign fs.bvalid  = 1'b0;
    assign fs.bresp   = 2'b00;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_rv <= 1'b0; f_rd <= '0;
        end else if (fs.arvalid && fs.arready) begin
            f_rv <= 1'b1; f_rd <= fs.araddr;
        end else if (fs.rvalid && fs.rready) begin
            f_rv <= 1'b0;
        end
    end

    logic [31:0] rr_log [$];
    logic [31:0] fx_log [$];
    int          r_t    [$];

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rs.arvalid && rs.arready) rr_log.push_back(rs.araddr);
        if (rs.rvalid && rs.rready)   r_t.push_back(cyc_n);
        if (fs.arvalid && fs.arready) fx_log.push_back(fs.araddr);
        if (rs.wvalid && rs.wready) begin
            s_wcnt <= s_wcnt + 1;
            s_wd   <= rs.wdata;
            s_wm   <= rs.wmask;
        end
    end

    axi_lite_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .m       (mr),
        .s       (rs)
    );

    axi_lite_rr_arbiter #(.NUM_MASTERS(3), .ARB_MODE(0)) u_fx (
        .clk     (clk),
        .reset_n (reset_n),
        .m       (mf),
        .s       (fs)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        arv = 4'hF; awv = 4'hF; wv = 4'hF;
        rrdy = 4'hF; brdy = 4'hF;
        farv = 3'b111; sl_wrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ara[i] = 32'h1000 + 32'(i * 16);
            awa[i] = 32'h2000 + 32'(i * 16);
            wd[i]  = '0;
            wm[i]  = '0;
        end

        // Reset holds every outgoing valid/ready low.
        cyc(2);
        chk("rst_s_arvalid", 32'(rs.arvalid), 0);
        chk("rst_s_awvalid", 32'(rs.awvalid), 0);
        chk("rst_s_wvalid", 32'(rs.wvalid), 0);
        chk("rst_m_arready", 32'(arr), 0);
        chk("rst_fx_arvalid", 32'(fs.arvalid), 0);

        arv = '0; awv = '0; wv = '0; farv = '0;
        reset_n = 1'b1;
        cyc(1);
        rr_log.delete();
        r_t.delete();

        // Round-robin among m0..m2 with a 0-wait slave.
        arv = 4'b0111;
        cyc(1);
        chk("rr_lat_arvalid", 32'(rs.arvalid), 1);
        chk("rr_lat_araddr", rs.araddr, 32'h1000);
        chk("rr_arready_own", 32'(arr), 32'h1);
        cyc(1);
        chk("rr_rvalid_own", 32'(rv), 32'h1);
        chk("rr_rdata_bcast", mr[2].rdata, 32'h5A5A1000);
        cyc(10);
        arv = '0;
        chk("rr_order_n", 32'(rr_log.size()), 4);
        chk("rr_order0", rr_log[0], 32'h1000);
        chk("rr_order1", rr_log[1], 32'h1010);
        chk("rr_order2", rr_log[2], 32'h1020);
        chk("rr_order3", rr_log[3], 32'h1000);
        chk("rr_r_gap", 32'(r_t[1] - r_t[0]), 3);
        chk("rr_r_gap3", 32'(r_t[3] - r_t[0]), 9);

        // Pointer wrap: grant m3, then all request -> m0.
        arv = 4'b1000;
        cyc(1);
        chk("wrap_m3_addr", rs.araddr, 32'h1030);
        cyc(1);
        chk("wrap_m3_rvalid", 32'(rv), 32'h8);
        cyc(1);
        arv = 4'b1111;
        cyc(1);
        chk("wrap_m0_addr", rs.araddr, 32'h1000);
        chk("wrap_m0_arready", 32'(arr), 32'h1);
        cyc(2);
        arv = '0;

        // Write with W two cycles ahead of AW.
        wd[1] = 32'hDEADBEEF; wm[1] = 4'hF;
        wv = 4'b0010;
        cyc(1);
        chk("wfirst_no_req", 32'(rs.wvalid), 0);
        chk("wfirst_wready", 32'(wr), 0);
        cyc(1);
        awv = 4'b0010;
        cyc(1);
        chk("wfirst_awvalid", 32'(rs.awvalid), 1);
        chk("wfirst_wvalid", 32'(rs.wvalid), 1);
        chk("wfirst_awaddr", rs.awaddr, 32'h2010);
        chk("wfirst_awready", 32'(awr), 32'h2);
        cyc(1);
        awv = '0; wv = '0;
        chk("wfirst_bvalid", 32'(bv), 32'h2);
        cyc(1);
        chk("wfirst_wcnt", 32'(s_wcnt), 1);
        chk("wfirst_wdata", s_wd, 32'hDEADBEEF);
        chk("wfirst_wmask", 32'(s_wm), 32'hF);
        chk("wfirst_bvalid_off", 32'(bv), 0);

        // Concurrent m0 read and m1 write; W stalled one cycle.
        sl_wrdy = 1'b0;
        wd[1] = 32'h12345678;
        arv = 4'b0001; awv = 4'b0010; wv = 4'b0010;
        cyc(1);
        chk("conc_arvalid", 32'(rs.arvalid), 1);
        chk("conc_awvalid", 32'(rs.awvalid), 1);
        chk("conc_wvalid", 32'(rs.wvalid), 1);
        cyc(1);
        arv = '0;
        chk("conc_aw_masked", 32'(rs.awvalid), 0);
        chk("conc_w_pending", 32'(rs.wvalid), 1);
        chk("conc_r_to_m0", 32'(rv), 32'h1);
        sl_wrdy = 1'b1;
        cyc(1);
        awv = '0; wv = '0;
        chk("conc_b_to_m1", 32'(bv), 32'h2);
        chk("conc_r_done", 32'(rv), 0);
        chk("conc_wcnt", 32'(s_wcnt), 2);
        cyc(1);
        chk("conc_wdata", s_wd, 32'h12345678);
        chk("conc_b_done", 32'(bv), 0);

        // Reset mid-read (R pending) and mid-write (W pending).
        rrdy = 4'b1011; sl_wrdy = 1'b0;
        arv = 4'b0100; awv = 4'b0100; wv = 4'b0100;
        cyc(2);
        arv = '0; awv = '0;
        chk("rstmid_rvalid_pre", 32'(rv), 32'h4);
        chk("rstmid_wvalid_pre", 32'(rs.wvalid), 1);
        cyc(1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_wvalid_async", 32'(rs.wvalid), 0);
        chk("rstmid_rvalid_async", 32'(rv), 0);
        wv = '0; sl_wrdy = 1'b1; rrdy = 4'hF;
        cyc(1);
        reset_n = 1'b1;
        #1;
        chk("rstmid_s_arvalid", 32'(rs.arvalid), 0);
        chk("rstmid_s_rvalid", 32'(rs.rvalid), 0);
        arv = 4'b0010;
        cyc(1);
        chk("rstmid_m1_addr", rs.araddr, 32'h1010);
        chk("rstmid_m1_arready", 32'(arr), 32'h2);
        cyc(1);
        arv = '0;
        chk("rstmid_m1_rvalid", 32'(rv), 32'h2);
        chk("rstmid_m1_rdata", mr[1].rdata, 32'h5A5A1010);
        cyc(1);
        chk("rstmid_m1_done", 32'(rv), 0);

        // Fixed priority: m2 starved until m0 drops.
        fx_log.delete();
        farv = 3'b101;
        cyc(1);
        chk("fx_first_addr", fs.araddr, 32'h1000);
        chk("fx_m2_arready", 32'(farr), 32'h1);
        cyc(8);
        farv = 3'b100;
        chk("fx_grants_n", 32'(fx_log.size()), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fx_grant%0d", i), fx_log[i], 32'h1000);
        cyc(1);
        chk("fx_m2_arvalid", 32'(fs.arvalid), 1);
        chk("fx_m2_addr", fs.araddr, 32'h1020);
        chk("fx_m2_own", 32'(farr), 32'h4);
        cyc(1);
        chk("fx_m2_rvalid", 32'(frv), 32'h4);
        cyc(1);
        farv = '0;
        chk("fx_grants_n2", 32'(fx_log.size()), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
